// File: rtl/ras_stack.sv
// Return-address stack: circular buffer of {valid, addr} entries addressed by a top pointer.
// A push into a full stack overwrites the oldest entry and pulses overflow_o for one cycle.
module ras_stack #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int TW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic            top_valid_o,
  output logic [VLEN-1:0] top_addr_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] LAST_C  = TW'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q;
  logic [VLEN-1:0]  addr_q [DEPTH];
  logic [TW-1:0]    tp_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic [TW-1:0]    tp_inc;
  logic [TW-1:0]    tp_dec;
  logic             full;

  // Explicit wrap keeps the pointer modulo DEPTH for non-power-of-two depths.
  always_comb begin
    tp_inc = (tp_q == LAST_C) ? '0 : tp_q + TW'(1);
    tp_dec = (tp_q == '0) ? LAST_C : tp_q - TW'(1);
    full   = (count_q == DEPTH_C);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (flush_i) begin
        valid_q <= '0;
        tp_q    <= '0;
        count_q <= '0;
      end else if (push_i && pop_i) begin
        valid_q[tp_q] <= 1'b1;
        addr_q[tp_q]  <= push_addr_i;
        if (count_q == '0) count_q <= CW'(1);
      end else if (push_i) begin
        tp_q            <= tp_inc;
        valid_q[tp_inc] <= 1'b1;
        addr_q[tp_inc]  <= push_addr_i;
        if (full) ovf_q <= 1'b1;
        else      count_q <= count_q + CW'(1);
      end else if (pop_i && count_q != '0) begin
        valid_q[tp_q] <= 1'b0;
        tp_q          <= tp_dec;
        count_q       <= count_q - CW'(1);
      end
    end
  end

  always_comb begin
    top_valid_o = valid_q[tp_q];
    top_addr_o  = addr_q[tp_q];
    count_o     = count_q;
    full_o      = full;
    empty_o     = (count_q == '0);
    overflow_o  = ovf_q;
  end

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: directed scenarios plus a long random run against a
// bounded-queue model of a return-address stack.
module tb_ras_stack;
  localparam int DEPTH = 2;
  localparam int VLEN  = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst, flush, push, pop;
  logic [VLEN-1:0] push_addr;
  logic            top_valid, full, empty, overflow;
  logic [VLEN-1:0] top_addr;
  logic [CW-1:0]   count;

  logic [VLEN-1:0] mq[$];
  logic            m_ovf;
  int              checks = 0;
  int              failures = 0;

  always #5 clk = ~clk;

  ras_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
    .push_addr_i(push_addr), .pop_i(pop), .top_valid_o(top_valid),
    .top_addr_o(top_addr), .count_o(count), .full_o(full),
    .empty_o(empty), .overflow_o(overflow)
  );

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stack semantics: newest at back; a push into a full stack drops the oldest.
  task automatic model_step();
    m_ovf = 1'b0;
    if (rst || flush) mq.delete();
    else if (push && pop) begin
      if (mq.size() > 0) mq[mq.size()-1] = push_addr;
      else mq.push_back(push_addr);
    end else if (push) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
      mq.push_back(push_addr);
    end else if (pop && mq.size() > 0) begin
      void'(mq.pop_back());
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "/valid"}, VLEN'(top_valid), VLEN'(mq.size() > 0));
    if (mq.size() > 0) check_eq({tag, "/addr"}, top_addr, mq[mq.size()-1]);
    check_eq({tag, "/count"}, VLEN'(count), VLEN'(mq.size()));
    check_eq({tag, "/full"}, VLEN'(full), VLEN'(mq.size() == DEPTH));
    check_eq({tag, "/empty"}, VLEN'(empty), VLEN'(mq.size() == 0));
    check_eq({tag, "/ovf"}, VLEN'(overflow), VLEN'(m_ovf));
  endtask

  task automatic cycle(input logic r, input logic f, input logic pu, input logic po,
                       input logic [VLEN-1:0] a, input string tag);
    rst = r; flush = f; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    #1;
    model_step();
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
    m_ovf = 1'b0;

    cycle(1, 0, 0, 0, '0, "reset");
    check_eq("reset/addr0", top_addr, '0);

    cycle(0, 0, 1, 0, 64'h8000_1000, "push_first");

    // Overflow: A is lost after C.
    cycle(1, 0, 0, 0, '0, "rst2");
    cycle(0, 0, 1, 0, 64'h100, "pushA");
    cycle(0, 0, 1, 0, 64'h200, "pushB");
    cycle(0, 0, 1, 0, 64'h300, "pushC");
    check_eq("ovf_pulse", VLEN'(overflow), 64'h1);
    check_eq("ovf_top", top_addr, 64'h300);
    cycle(0, 0, 0, 1, '0, "pop1");
    check_eq("pop1_top", top_addr, 64'h200);
    cycle(0, 0, 0, 1, '0, "pop2");
    check_eq("pop2_empty", VLEN'(empty), 64'h1);

    cycle(1, 0, 0, 0, '0, "rst3");
    cycle(0, 0, 0, 1, '0, "pop_empty");
    cycle(0, 0, 1, 0, 64'h40, "push40");
    check_eq("push40_top", top_addr, 64'h40);

    cycle(1, 0, 0, 0, '0, "rst4");
    cycle(0, 0, 1, 0, 64'h100, "s_push1");
    cycle(0, 0, 1, 0, 64'h200, "s_push2");
    cycle(0, 0, 1, 1, 64'h500, "replace");
    check_eq("replace_top", top_addr, 64'h500);
    cycle(0, 0, 0, 1, '0, "pop_after_rep");
    check_eq("rep_pop_top", top_addr, 64'h100);

    cycle(0, 0, 1, 1, 64'h600, "replace_empty_fill");
    cycle(0, 0, 1, 0, 64'h700, "fill2");
    cycle(0, 1, 1, 1, 64'h900, "flush_prio");

    cycle(0, 0, 0, 1, '0, "pop_on_flushed");
    cycle(0, 0, 1, 1, 64'h55, "replace_empty");
    cycle(1, 0, 1, 0, 64'h700, "rst_push");
    check_eq("rst_push/addr0", top_addr, '0);

    for (int i = 0; i < 12000; i++) begin
      logic r, f, pu, po;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 19) == 0);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      cycle(r, f, pu, po, {$urandom, $urandom}, "rand");
    end

    cycle(0, 0, 1, 0, 64'hdead_beef, "pre_final_rst");
    cycle(1, 0, 0, 0, '0, "final_rst");
    check_eq("final_rst/addr0", top_addr, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
